// File: rtl/demux1x4_deser_pkg.sv
// Lane-order constants shared by the 1:4 deserializer and the 4:1 mux/serializer.
// Both ends import this package so that they agree on which beat lands in which lane.
package demux1x4_deser_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] LANE0 = 2'd0;
  localparam logic [SEL_W-1:0] LANE1 = 2'd1;
  localparam logic [SEL_W-1:0] LANE2 = 2'd2;
  localparam logic [SEL_W-1:0] LANE3 = 2'd3;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic logic [SEL_W-1:0] lane_inc(input logic [SEL_W-1:0] i_lane);
    return i_lane + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux1x4_deser_dec.sv
// One-hot lane write-enable decoder: the lane addressed by i_sel is enabled
// only while i_en is high.
module demux1x4_dec
  import demux1x4_deser_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [LANES-1:0] o_we
);

  always_comb begin
    o_we = '0;
    if (i_en) begin
      o_we[i_sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1x4_deser.sv
// Registered 1:4 deserializer: steers serial beats into lane registers and
// presents each completed 4-lane word through a one-deep valid/ready output register.
module demux1x4_deser
  import demux1x4_deser_pkg::*;
#(
  parameter int W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       din,
  input  logic               din_valid,
  input  logic               sof,
  output logic [SEL_W-1:0]   sel,
  output logic [LANES*W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               sync_err,
  output logic               ovf
);

  logic [SEL_W-1:0]   r_sel;
  logic [W-1:0]       r_lane [LANES-1];
  logic [LANES*W-1:0] r_dout;
  logic               r_sync_err;
  logic               r_ovf;
  out_state_t         r_state;

  logic [SEL_W-1:0]   w_wr_sel;
  logic [LANES-1:0]   w_we;
  logic               w_complete;
  logic [LANES*W-1:0] w_word;
  out_state_t         w_state_nxt;
  logic               w_load;
  logic               w_ovf_nxt;

  // A start-of-frame beat always lands in lane 0, whatever the counter says.
  assign w_wr_sel = sof ? LANE0 : r_sel;

  demux1x4_dec u_dec (
    .i_sel (w_wr_sel),
    .i_en  (din_valid),
    .o_we  (w_we)
  );

  // Lane 3 is never stored: its beat goes straight into the output word.
  assign w_complete = w_we[LANE3];

  always_comb begin
    w_word = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      w_word[k*W +: W] = r_lane[k];
    end
    w_word[LANE3*W +: W] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel      <= LANE0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= din_valid && sof && (r_sel != LANE0);
      if (din_valid) begin
        r_sel <= sof ? LANE1 : lane_inc(r_sel);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES - 1; k++) begin
        r_lane[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LANES - 1; k++) begin
        if (w_we[k]) begin
          r_lane[k] <= din;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovf_nxt   = 1'b0;
    case (r_state)
      OUT_EMPTY: begin
        if (w_complete) begin
          w_load      = 1'b1;
          w_state_nxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (w_complete) begin
          // Consumer taking the held word frees the slot for the new one in the same cycle.
          if (dout_ready) begin
            w_load = 1'b1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end else if (dout_ready) begin
          w_state_nxt = OUT_EMPTY;
        end
      end
      default: w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OUT_EMPTY;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_load) begin
        r_dout <= w_word;
      end
    end
  end

  assign sel        = r_sel;
  assign dout       = r_dout;
  assign dout_valid = (r_state == OUT_FULL);
  assign sync_err   = r_sync_err;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_demux1x4_deser.sv
// Directed bench for demux1x4_deser: expected words go into a queue, a forked
// monitor pops and compares on every dout handshake.
module tb_demux1x4_deser;
  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sof;
  logic [1:0]   sel;
  logic [4*W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic         sync_err;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  int n_ovf  = 0;
  int n_sync = 0;
  logic [4*W-1:0] exp_q [$];

  demux1x4_deser #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sync_err   (sync_err),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic beat(input logic d, input logic s);
    din       = d;
    sof       = s;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = '0;
  endtask

  task automatic word4(input logic [3:0] v, input bit push);
    if (push) exp_q.push_back(v);
    beat(v[0], 1'b1);
    beat(v[1], 1'b0);
    beat(v[2], 1'b0);
    beat(v[3], 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    sof        = 1'b0;
    dout_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (ovf) n_ovf++;
        if (sync_err) n_sync++;
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word got %h want none", dout);
          end else begin
            chk("word", 32'(dout), 32'(exp_q.pop_front()));
          end
        end
      end
    join_none

    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // basic assembly: beats 1,0,1,1 -> 4'b1101
    chk("basic_sel0", 32'(sel), 32'd0);
    beat(1'b1, 1'b1);
    chk("basic_sel1", 32'(sel), 32'd1);
    beat(1'b0, 1'b0);
    chk("basic_sel2", 32'(sel), 32'd2);
    beat(1'b1, 1'b0);
    chk("basic_sel3", 32'(sel), 32'd3);
    exp_q.push_back(4'b1101);
    beat(1'b1, 1'b0);
    chk("basic_sel_wrap", 32'(sel), 32'd0);
    chk("basic_valid", 32'(dout_valid), 32'd1);
    chk("basic_dout", 32'(dout), 32'hd);
    @(posedge clk);
    #1;
    chk("basic_valid_drop", 32'(dout_valid), 32'd0);

    // exhaustive sweep, back-to-back
    for (int w = 0; w < 16; w++) begin
      word4(4'(w), 1'b1);
    end
    @(posedge clk);
    #1;
    chk("sweep_ovf_count", 32'(n_ovf), 32'd0);
    chk("sweep_sync_count", 32'(n_sync), 32'd0);
    chk("sweep_drained", 32'(exp_q.size()), 32'd0);

    // resync: 1,1 then sof 0, then 1,1,1 -> 4'b1110
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    chk("resync_pulse", 32'(sync_err), 32'd1);
    chk("resync_sel", 32'(sel), 32'd1);
    exp_q.push_back(4'b1110);
    beat(1'b1, 1'b0);
    chk("resync_pulse_end", 32'(sync_err), 32'd0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    chk("resync_dout", 32'(dout), 32'he);
    @(posedge clk);
    #1;
    chk("resync_count", 32'(n_sync), 32'd1);

    // backpressure: A = 0011 held, B = 1100 dropped
    dout_ready = 1'b0;
    word4(4'b0011, 1'b1);
    chk("bp_valid_a", 32'(dout_valid), 32'd1);
    chk("bp_dout_a", 32'(dout), 32'h3);
    word4(4'b1100, 1'b0);
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk("bp_dout_held", 32'(dout), 32'h3);
    chk("bp_valid_held", 32'(dout_valid), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_ovf_end", 32'(ovf), 32'd0);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_release", 32'(dout_valid), 32'd0);
    chk("bp_ovf_count", 32'(n_ovf), 32'd1);

    // reset mid-frame, with a word also held
    dout_ready = 1'b0;
    word4(4'b1010, 1'b0);
    chk("mid_held", 32'(dout_valid), 32'd1);
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    chk("mid_sel_pre", 32'(sel), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_sel_rst", 32'(sel), 32'd0);
    chk("mid_valid_rst", 32'(dout_valid), 32'd0);
    chk("mid_dout_rst", 32'(dout), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    word4(4'b0101, 1'b1);
    chk("mid_dout_after", 32'(dout), 32'h5);

    // X on beat 2 reaches only lane 2
    exp_q.push_back(4'b0x11);
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    chk("x_sel_pre", 32'(sel), 32'd2);
    beat(1'bx, 1'b0);
    chk("x_sel_adv", 32'(sel), 32'd3);
    beat(1'b0, 1'b0);
    chk("x_sel_wrap", 32'(sel), 32'd0);
    chk("x_valid", 32'(dout_valid), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    chk("final_sync_count", 32'(n_sync), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1x4_deser.md
# demux1x4_deser

Registered 1-to-4 demultiplexer / deserializer. It is the receive-side counterpart of the 4:1 mux: a serializer that steps the mux select 0→1→2→3 drives one lane per beat onto a single line, and this block steers each beat back into its lane register. Once all four lanes are filled, it presents the re-assembled word with a valid/ready handshake. It sits between the serial line and any consumer of the parallel word.

## Interface
- `W`, default 1: width of one lane (one serial beat).
- `clk` input, 1: rising-edge clock.
- `rst` input, 1: asynchronous, active-high reset.
- `din` input, W: serial beat.
- `din_valid` input, 1: `din` holds a beat this cycle. The block always accepts it; there is no input backpressure.
- `sof` input, 1: start of frame. Qualified by `din_valid`; the beat is forced to lane 0.
- `sel` output, 2: index of the lane the next valid beat will fill.
- `dout` output, 4*W: assembled word. Lane k is at `dout[k*W +: W]`.
- `dout_valid` output, 1: `dout` holds an unconsumed word.
- `dout_ready` input, 1: consumer takes the word when `dout_valid && dout_ready`.
- `sync_err` output, 1: one-cycle pulse when `sof` arrives with `sel != 0`.
- `ovf` output, 1: one-cycle pulse when a completed word is dropped.

## Operation
- **Lane counter (`sel`)**
  - On `din_valid && !sof`: write `din` to lane register `sel`, then `sel <= sel + 1` (wraps 3→0).
  - On `din_valid && sof`: write `din` to lane 0 and set `sel <= 1`.
  - If `sof` arrives while `sel != 0`, pulse `sync_err`. Lanes already written in that partial frame are discarded; no word is emitted for it.
  - With `din_valid` low, `sel` and the lane registers hold.
- **Word completion**
  - A word completes when a beat is accepted with `sel == 3` and `sof` low.
  - If `sof` is high on that beat, the frame restarts instead and nothing completes.
  - At completion, lanes 0..2 plus the current `din` are loaded into the output register in one step.
- **Output register (two states)**
  - EMPTY: `dout_valid = 0`.
  - FULL: `dout_valid = 1`; `dout` is stable until consumed.
  - EMPTY → FULL on completion.
  - FULL → EMPTY on `dout_ready` with no completion in the same cycle.
  - FULL with `dout_ready` and a completion in the same cycle: load the new word and stay FULL (back-to-back transfer, no bubble).
  - FULL with no `dout_ready` and a completion: drop the new word, keep the held word, pulse `ovf`.
- **X handling**: an X on `din` propagates into the lane register only. `sel` advances on `din_valid` alone and never depends on `din`.

## Timing
- Reset values: `sel = 0`, all lane registers 0, `dout = 0`, `dout_valid = 0`, `sync_err = 0`, `ovf = 0`.
- An asserted `rst` clears all of the above immediately, including a partial frame or a held word in mid-operation.
- Latency: completing beat sampled at edge N → `dout_valid = 1` with the new `dout` after edge N. The word is visible in the cycle following its last beat.
- Throughput: one word per 4 valid beats. With `dout_ready` tied high, `ovf` never fires.
- `sync_err` and `ovf` are registered. Each is high for exactly the one cycle after the offending edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package holds:
  - `LANES = 4`
  - `SEL_W = 2`
  - lane-index constants `LANE0..LANE3`, shared with the 4:1 mux and its serializer so that both ends agree on lane order.
- Natural sub-module: `demux1x4_dec`, a combinational 2→4 one-hot lane-write-enable decoder from `sel`, gated by `din_valid`. It is reused by the lane registers.
- Everything else lives in the top module: the counter, the lane registers, and the output register FSM.

## Test plan
- **Basic assembly**: reset, then with W=1 and `dout_ready = 1`, send beats 1,0,1,1 with `sof` on the first. Expect `dout = 4'b1101` and a one-cycle `dout_valid` after the 4th beat; `sel` sequence 0,1,2,3,0.
- **Exhaustive sweep**: W=1, send all 16 four-beat words 0000..1111 back-to-back. Expect each `dout` equal to the input word, with `ovf = 0` and `sync_err = 0` throughout.
- **Resync**: send 1,1 then `sof` with 0, then 1,1,1. Expect a `sync_err` pulse on the `sof` beat, `dout = 4'b1110`, and no word emitted for the partial frame.
- **Backpressure**: hold `dout_ready = 0` and send two full words, A = 4'b0011 then B = 4'b1100. Expect `dout` to stay 0011, `ovf` to pulse after B's last beat, and B to be dropped. Then `dout_ready = 1` → `dout_valid` goes low next cycle.
- **Reset mid-frame**: send 2 beats, assert `rst` asynchronously between edges. Expect `sel = 0` and `dout_valid = 0` immediately. A following full frame of 0101 must assemble to 0101.
- **X input**: drive `din = x` on beat 2 of a frame. Expect `sel` to advance normally and only the lane 2 bit of `dout` to be x.
